// File: rtl/fp16_accum_if.sv
// fp16_accum_if: element input stream and vector-sum output stream of fp16_accum_seq.
interface fp16_accum_if #(parameter int CNT_W = 8);
  logic             in_valid;
  logic             in_ready;
  logic [15:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [15:0]      out_sum;
  logic [CNT_W-1:0] out_count;
  modport master (output in_valid, in_data, in_last, out_ready,
                  input  in_ready, out_valid, out_sum, out_count);
  modport slave  (input  in_valid, in_data, in_last, out_ready,
                  output in_ready, out_valid, out_sum, out_count);
endinterface

// File: rtl/fp16_accum_seq.sv
// fp16_accum_seq: sequences an fp16 stream through an external pipelined adder, one sum per vector.
// Optional sticky-NaN short-circuit enabled by defining FP16_ACCUM_NAN_STICKY_EN.
module fp16_accum_seq #(
  parameter int ADD_LATENCY = 2,
  parameter int CNT_W       = 8
) (
  input  logic        clk,
  input  logic        rst,
  fp16_accum_if.slave io,
  output logic [15:0] add_a_o,
  output logic [15:0] add_b_o,
  input  logic [15:0] add_result_i
);
  localparam int WCNT_W = $clog2(ADD_LATENCY + 1);
  typedef enum logic [1:0] {IDLE, WAIT, OUT} state_t;
  state_t            state_q, state_d;
  logic [15:0]       acc_q, acc_d, a_q, a_d, b_q, b_d;
  logic              first_q, first_d, last_q, last_d, skip;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
  assign cnt_inc = &cnt_q ? cnt_q : cnt_q + CNT_W'(1);
`ifdef FP16_ACCUM_NAN_STICKY_EN
  logic nan_q, nan_d;
  assign skip       = nan_q | (&io.in_data[14:10] & |io.in_data[9:0]);
  assign io.out_sum = nan_q ? 16'h7C01 : acc_q;
`else
  assign skip       = 1'b0;
  assign io.out_sum = acc_q;
`endif
  // handshake flags come from the state register only; reset forces them low
  assign io.in_ready  = (state_q == IDLE) & ~rst;
  assign io.out_valid = (state_q == OUT) & ~rst;
  assign io.out_count = cnt_q;
  assign add_a_o      = a_q;
  assign add_b_o      = b_q;
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    a_d     = a_q;
    b_d     = b_q;
    first_d = first_q;
    last_d  = last_q;
    wcnt_d  = wcnt_q;
    cnt_d   = cnt_q;
`ifdef FP16_ACCUM_NAN_STICKY_EN
    nan_d   = nan_q;
`endif
    case (state_q)
      IDLE: if (io.in_valid) begin
        cnt_d   = first_q ? CNT_W'(1) : cnt_inc;
        first_d = 1'b0;
`ifdef FP16_ACCUM_NAN_STICKY_EN
        nan_d   = skip;
`endif
        if (first_q || skip) begin
          acc_d   = first_q ? io.in_data : acc_q;
          state_d = io.in_last ? OUT : IDLE;
        end else begin
          a_d     = acc_q;
          b_d     = io.in_data;
          last_d  = io.in_last;
          wcnt_d  = WCNT_W'(ADD_LATENCY);
          state_d = WAIT;
        end
      end
      WAIT: begin
        wcnt_d = wcnt_q - WCNT_W'(1);
        if (wcnt_q == '0) begin
          acc_d   = add_result_i;
          wcnt_d  = '0;
          state_d = last_q ? OUT : IDLE;
        end
      end
      OUT: if (io.out_ready) begin
        state_d = IDLE;
        first_d = 1'b1;
        cnt_d   = '0;
`ifdef FP16_ACCUM_NAN_STICKY_EN
        nan_d   = 1'b0;
`endif
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      a_q     <= '0;
      b_q     <= '0;
      first_q <= 1'b1;
      last_q  <= 1'b0;
      wcnt_q  <= '0;
      cnt_q   <= '0;
`ifdef FP16_ACCUM_NAN_STICKY_EN
      nan_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      a_q     <= a_d;
      b_q     <= b_d;
      first_q <= first_d;
      last_q  <= last_d;
      wcnt_q  <= wcnt_d;
      cnt_q   <= cnt_d;
`ifdef FP16_ACCUM_NAN_STICKY_EN
      nan_q   <= nan_d;
`endif
    end
  end
endmodule

// File: tb/tb_fp16_accum_seq.sv
// tb_fp16_accum_seq: directed vectors against a real-arithmetic fp16 adder and a vector-fold scoreboard.
module tb_fp16_accum_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] add_a, add_b, add_result;
  logic [15:0] p0, p1;
  int          cyc = 0;
  int          checks = 0;
  int          failures = 0;
  logic [15:0] q_sum[$];
  int          q_cnt[$];
  logic [15:0] m_acc;
  logic        m_first = 1'b1;
  logic        m_nan = 1'b0;
  int          m_cnt = 0;
  logic        hold = 1'b0;
  logic [15:0] hsum;
  logic [7:0]  hcnt;
  int          h0, h1, h2;

  fp16_accum_if #(.CNT_W(8)) io ();

  fp16_accum_seq #(.ADD_LATENCY(2), .CNT_W(8)) dut (
    .clk(clk), .rst(rst), .io(io),
    .add_a_o(add_a), .add_b_o(add_b), .add_result_i(add_result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic real pw2(input int e);
    real r = 1.0;
    for (int i = 0; i < (e < 0 ? -e : e); i++) r = (e < 0) ? r / 2.0 : r * 2.0;
    return r;
  endfunction

  function automatic real h2r(input logic [15:0] h);
    real v = (h[14:10] == 5'd0) ? real'(h[9:0]) * pw2(-24)
                                : real'(1024 + int'(h[9:0])) * pw2(int'(h[14:10]) - 25);
    return h[15] ? -v : v;
  endfunction

  function automatic logic [15:0] r2h(input real r);
    real a = (r < 0.0) ? -r : r;
    int  e = 15;
    int  m;
    if (r == 0.0) return 16'h0000;
    while (a >= 2.0) begin a = a / 2.0; e++; end
    while (a < 1.0) begin a = a * 2.0; e--; end
    m = int'((a - 1.0) * 1024.0);
    return {r < 0.0, e[4:0], m[9:0]};
  endfunction

  function automatic logic is_nan(input logic [15:0] h);
    return (h[14:10] == 5'h1F) && (h[9:0] != 10'd0);
  endfunction

  function automatic logic [15:0] fadd(input logic [15:0] a, input logic [15:0] b);
    if (is_nan(a) || is_nan(b)) return 16'h7E00;
    if (a[14:10] == 5'h1F) return a;
    if (b[14:10] == 5'h1F) return b;
    return r2h(h2r(a) + h2r(b));
  endfunction

  // external adder: result reflects operands two edges after they change
  always @(posedge clk or posedge rst)
    if (rst) begin p0 <= '0; p1 <= '0; end
    else begin p0 <= fadd(add_a, add_b); p1 <= p0; end
  assign add_result = p1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at cycle %0d", nm, act, exp, cyc);
    end
  endtask

  task automatic model_accept(input logic [15:0] d, input logic l);
    m_acc   = m_first ? d : fadd(m_acc, d);
    m_first = 1'b0;
    m_nan   = m_nan | is_nan(d);
    if (m_cnt < 255) m_cnt++;
    if (l) begin
`ifdef FP16_ACCUM_NAN_STICKY_EN
      q_sum.push_back(m_nan ? 16'h7C01 : m_acc);
`else
      q_sum.push_back(m_acc);
`endif
      q_cnt.push_back(m_cnt);
      m_first = 1'b1; m_cnt = 0; m_nan = 1'b0;
    end
  endtask

  task automatic model_flush();
    q_sum.delete(); q_cnt.delete();
    m_first = 1'b1; m_cnt = 0; m_nan = 1'b0;
  endtask

  task automatic send(input logic [15:0] d, input logic l, output int hc);
    io.in_valid = 1'b1; io.in_data = d; io.in_last = l; hc = -1;
    for (int i = 0; i < 40 && hc < 0; i++) begin
      @(negedge clk);
      if (io.in_ready) hc = cyc;
    end
    if (hc < 0) begin
      chk("in_accept_timeout", 0, 1);
      io.in_valid = 1'b0;
    end else begin
      @(posedge clk);
      model_accept(d, l);
      #1;
      if (l) io.in_valid = 1'b0;
    end
  endtask

  task automatic wait_out(input string nm, input logic [15:0] s, input logic [7:0] c);
    bit got = 0;
    for (int i = 0; i < 40 && !got; i++) begin
      @(negedge clk);
      got = io.out_valid;
    end
    if (!got) chk({nm, "_out_timeout"}, 0, 1);
    else begin
      chk({nm, "_sum"}, io.out_sum, s);
      chk({nm, "_count"}, io.out_count, c);
    end
    if (io.out_ready) begin @(posedge clk); #1; end
  endtask

  always @(negedge clk) begin
    if (rst) hold = 1'b0;
    else begin
      if (hold) begin
        chk("hold_valid", io.out_valid, 1);
        chk("hold_sum", io.out_sum, hsum);
        chk("hold_count", io.out_count, hcnt);
      end
      if (io.out_valid) begin
        if (q_sum.size() == 0) chk("unexpected_out", 1, 0);
        else begin
          chk("model_sum", io.out_sum, q_sum[0]);
          chk("model_count", io.out_count, q_cnt[0]);
          if (io.out_ready) begin void'(q_sum.pop_front()); void'(q_cnt.pop_front()); end
        end
      end
      hold = io.out_valid && !io.out_ready;
      hsum = io.out_sum;
      hcnt = io.out_count;
    end
  end

  initial begin
    io.in_valid = 0; io.in_data = '0; io.in_last = 0; io.out_ready = 1;
    #1;
    chk("rst_in_ready", io.in_ready, 0);
    chk("rst_out_valid", io.out_valid, 0);
    chk("rst_add_a", add_a, 0);
    chk("rst_add_b", add_b, 0);
    chk("rst_out_sum", io.out_sum, 0);
    chk("rst_out_count", io.out_count, 0);
    repeat (2) @(posedge clk);
    #1 rst = 0;
    @(negedge clk);
    chk("post_rst_in_ready", io.in_ready, 1);
    @(posedge clk); #1;
    // single element passes through, out_valid right after the handshake edge
    send(16'hC500, 1, h0);
    chk("single_valid_next", io.out_valid, 1);
    wait_out("single", 16'hC500, 1);
    // three elements with in_valid held high
    send(16'h3C00, 0, h0);
    send(16'h4000, 0, h1);
    send(16'h3C00, 1, h2);
    chk("thru_h1", h1 - h0, 1);
    chk("thru_h2", h2 - h0, 5);
    wait_out("three", 16'h4400, 3);
    // backpressure: output held six cycles
    io.out_ready = 0;
    send(16'h3800, 0, h0);
    send(16'h3800, 1, h1);
    wait_out("bp", 16'h3C00, 2);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("bp_valid", io.out_valid, 1);
      chk("bp_sum", io.out_sum, 16'h3C00);
      chk("bp_in_ready", io.in_ready, 0);
    end
    @(posedge clk); #1 io.out_ready = 1;
    @(posedge clk); #1;
    send(16'h3C00, 1, h0);
    wait_out("after_bp", 16'h3C00, 1);
    // cancellation
    send(16'h4200, 0, h0);
    send(16'hC200, 1, h1);
    wait_out("cancel", 16'h0000, 2);
    // bit-exact single-element specials
    send(16'h8000, 1, h0);
    wait_out("neg_zero", 16'h8000, 1);
    send(16'h7C00, 1, h0);
    wait_out("inf", 16'h7C00, 1);
    // reset while the add is in flight
    send(16'h3C00, 0, h0);
    send(16'h4000, 1, h1);
    @(posedge clk); #1 rst = 1;
    #1;
    chk("wrst_out_valid", io.out_valid, 0);
    chk("wrst_in_ready", io.in_ready, 0);
    chk("wrst_add_a", add_a, 0);
    chk("wrst_count", io.out_count, 0);
    model_flush();
    repeat (2) @(posedge clk);
    #1 rst = 0;
    send(16'h4000, 1, h0);
    wait_out("after_rst", 16'h4000, 1);
    // NaN handling
    send(16'h3C00, 0, h0);
    send(16'h7E00, 0, h1);
    send(16'h4000, 1, h2);
`ifdef FP16_ACCUM_NAN_STICKY_EN
    chk("nan_fast_accept", h2 - h1, 1);
    wait_out("nan", 16'h7C01, 3);
`else
    chk("nan_adder_timing", h2 - h1, 4);
    wait_out("nan", 16'h7E00, 3);
`endif
    // element count saturates at all-ones
    send(16'h3C00, 0, h0);
    for (int i = 0; i < 258; i++) send(16'h0000, 0, h1);
    send(16'h0000, 1, h1);
    wait_out("sat", 16'h3C00, 8'hFF);
    repeat (4) @(negedge clk);
    chk("queue_drained", q_sum.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout actual=%0d required=done", cyc);
    $fatal(1, "timeout");
  end
endmodule

// File: doc/fp16_accum_seq.md
# fp16_accum_seq

Sequencer that sits directly upstream of the team's pipelined fp16 adder and turns a valid/ready stream of half-precision values into one running sum per vector. It accepts elements with a `last` marker, drives the adder's two operand inputs, waits out the adder's fixed latency, captures the sum, and presents the vector total on a valid/ready output. Only one addition is ever in flight, so no feedback hazard exists.

## Interface
- `ADD_LATENCY`, default 2: number of rising edges from the adder's operands changing to its `result` reflecting them; must be ≥1.
- `CNT_W`, default 8: width of the element counter.
- `clk` in 1: clock, rising edge.
- `rst` in 1: reset, asynchronous, active-high.
- `in_valid` in 1: input element valid.
- `in_ready` out 1: block accepts an element this cycle.
- `in_data` in 16: fp16 element.
- `in_last` in 1: element is the final one of its vector.
- `add_a` out 16: adder operand A, registered. Carries the accumulator.
- `add_b` out 16: adder operand B, registered. Carries the new element.
- `add_result` in 16: adder result.
- `out_valid` out 1: vector sum available.
- `out_ready` in 1: downstream accepts the sum.
- `out_sum` out 16: fp16 vector sum.
- `out_count` out CNT_W: number of elements in the vector. Saturates at all-ones.
- Integration: the adder's active-low reset is tied to `~rst`.

## Operation
- States:
  - IDLE: `in_ready`=1.
  - WAIT: `in_ready`=0.
  - OUT: `in_ready`=0 and `out_valid`=1.
  - `in_ready` and `out_valid` are decoded from the state register only, with no combinational path from `in_valid` or `out_ready`.
- Internal registers: `acc`[15:0], `first` (1 = accumulator empty), `last_q`, `wcnt`, `count`.
- IDLE, on `in_valid`&`in_ready` with `first`=1:
  - `acc`←`in_data`; `count`←1; `first`←0.
  - No add is issued.
  - Next state is OUT if `in_last`, otherwise IDLE.
- IDLE, on `in_valid`&`in_ready` with `first`=0:
  - `add_a`←`acc`; `add_b`←`in_data`; `last_q`←`in_last`.
  - `count`←`count`+1, saturating.
  - `wcnt`←`ADD_LATENCY`; next state WAIT.
- WAIT:
  - `wcnt` decrements once per cycle.
  - On the cycle `wcnt`==0: `acc`←`add_result`; next state is OUT if `last_q`, otherwise IDLE.
  - `add_a`/`add_b` hold their values throughout WAIT.
- OUT:
  - `out_sum`=`acc` and `out_count`=`count`, both held stable while `out_valid`=1 and `out_ready`=0.
  - On `out_ready`=1: next state IDLE; `first`←1; `count`←0.
- Arithmetic: no arithmetic in this block. All summation, rounding and special-value handling is done by the adder. Vectors of length 1 pass `in_data` through bit-exact, including NaN, Inf and -0.
- Reset mid-operation: any partial sum and any pending output are discarded. The adder result in flight is ignored.

## Timing
- Reset values:
  - State IDLE, so `in_ready`=1 once `rst` deasserts; during reset `in_ready`=0 and `out_valid`=0.
  - `add_a`=`add_b`=16'h0000, `out_sum`=16'h0000, `out_count`=0.
  - `first`=1, `wcnt`=0.
- Add issue: handshake at edge N loads `add_a`/`add_b`; `add_result` is sampled at edge N+`ADD_LATENCY`+1 (N+3 by default).
- Throughput: with the default latency, non-first elements are accepted at most once per 4 cycles. First elements are accepted at 1 per cycle.
- Output latency: `out_valid` rises the cycle after the edge that completes the vector (final handshake for a 1-element vector, or the `add_result` capture).
- Handshakes:
  - An input handshake is `in_valid`&`in_ready`; an output handshake is `out_valid`&`out_ready`.
  - Upstream may hold `in_valid` high indefinitely; data must be stable until accepted.

## Configuration
- `FP16_ACCUM_NAN_STICKY_EN` defined:
  - A sticky `nan_q` flag is set when any accepted element has exp=5'h1F and mant≠0.
  - Once set, further elements are accepted at 1 per cycle with no add issued (IDLE→IDLE, or →OUT on last).
  - `out_sum`=16'h7C01 for that vector; `nan_q` clears on the output handshake.
- Not defined: NaN elements go through the adder like any other value, with identical timing.

## Test plan
- Single element: `in_data`=16'hC500, `in_last`=1 -> `out_sum`=16'hC500, `out_count`=1, `out_valid` one cycle after the handshake.
- Three elements, 16'h3C00, 16'h4000, 16'h3C00, `in_valid` held high -> `out_sum`=16'h4400, `out_count`=3. Handshakes occur at cycles 0, 1 and 5, and `in_ready` is low exactly 3 cycles after each add issue.
- Backpressure: sum 16'h3800+16'h3800 with `out_ready`=0 for 6 cycles -> `out_sum`=16'h3C00 held stable and `in_ready`=0 throughout. After the output handshake, a new vector starts with `first`=1.
- Cancellation: 16'h4200 then 16'hC200 -> `out_sum`=16'h0000, `out_count`=2.
- Reset in WAIT: assert `rst` one cycle after the second handshake -> `out_valid`=0, `in_ready`=0 during reset. The next vector of 16'h4000 alone yields 16'h4000 with count 1.
- With `FP16_ACCUM_NAN_STICKY_EN` defined: 16'h3C00, 16'h7E00, 16'h4000(last) -> `out_sum`=16'h7C01 and the third element is accepted the cycle after the NaN. Without the macro, the result equals the adder's output.
